// File: rtl/rs_issue_scheduler_if.sv
// Issue-port bundle between the RS scheduler and the three FU classes:
// registered valid/index/tag towards the FUs, per-class ready back.
interface rs_issue_scheduler_if #(
  parameter int IDX_W     = 3,
  parameter int ROB_TAG_W = 5
);
  logic [2:0]             issue_valid;
  logic [3*IDX_W-1:0]     issue_idx;
  logic [3*ROB_TAG_W-1:0] issue_rob_tag;
  logic [2:0]             fu_ready;

  modport master (
    output issue_valid,
    output issue_idx,
    output issue_rob_tag,
    input  fu_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_idx,
    input  issue_rob_tag,
    output fu_ready
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// RS issue scheduler: per FU class, picks the oldest ready entry
// (starved entries first) and holds it on a registered issue port.
module rs_issue_scheduler #(
  parameter int NUM_RS       = 6,
  parameter int ROB_TAG_W    = 5,
  parameter int IDX_W        = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_RS-1:0]           entry_ready,
  input  logic [2*NUM_RS-1:0]         entry_class,
  input  logic [ROB_TAG_W*NUM_RS-1:0] entry_rob_tag,
  input  logic [ROB_TAG_W-1:0]        rob_head,
  input  logic [NUM_RS-1:0]           entry_free,
  input  logic [NUM_RS-1:0]           squash_vec,
  rs_issue_scheduler_if.master        iss,
  output logic [NUM_RS-1:0]           issued_vec
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ISSUED
  } state_e;

  state_e               state_q [NUM_RS];
  state_e               state_d [NUM_RS];
  logic [CNT_W-1:0]     cnt_q   [NUM_RS];
  logic [CNT_W-1:0]     cnt_d   [NUM_RS];
  logic [2:0]           vld_q, vld_d;
  logic [IDX_W-1:0]     idx_q   [3];
  logic [IDX_W-1:0]     idx_d   [3];
  logic [ROB_TAG_W-1:0] tag_q   [3];
  logic [ROB_TAG_W-1:0] tag_d   [3];

  logic [1:0]           cls     [NUM_RS];
  logic [ROB_TAG_W-1:0] tag     [NUM_RS];
  logic [ROB_TAG_W-1:0] age     [NUM_RS];
  logic [NUM_RS-1:0]    kill_e, elig, starved, picked, done;
  logic [2:0]           xfer, kill, load, sel_any, sel_st;
  logic [IDX_W-1:0]     sel_idx [3];
  logic [ROB_TAG_W-1:0] sel_tag [3];
  logic [ROB_TAG_W-1:0] sel_age [3];

  // Age wraps modulo the tag space, so head-relative distance orders entries.
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      cls[i]     = entry_class[2*i +: 2];
      tag[i]     = entry_rob_tag[ROB_TAG_W*i +: ROB_TAG_W];
      age[i]     = tag[i] - rob_head;
      kill_e[i]  = squash_vec[i] | entry_free[i];
      starved[i] = cnt_q[i] == LIMIT;
      elig[i]    = state_q[i] == IDLE && entry_ready[i]
                && cls[i] != 2'd3 && !kill_e[i];
    end
  end

  always_comb begin
    picked = '0;
    for (int c = 0; c < 3; c++) begin
      xfer[c]    = vld_q[c] & iss.fu_ready[c];
      kill[c]    = 1'b0;
      sel_any[c] = 1'b0;
      sel_st[c]  = 1'b0;
      sel_idx[c] = '0;
      sel_tag[c] = '0;
      sel_age[c] = '0;
      for (int i = 0; i < NUM_RS; i++) begin
        if (vld_q[c] && kill_e[i] && idx_q[c] == IDX_W'(i))
          kill[c] = 1'b1;
        if (elig[i] && cls[i] == 2'(c)) begin
          if (!sel_any[c]
              || (starved[i] && !sel_st[c])
              || (starved[i] == sel_st[c]
                  && age[i] < sel_age[c])) begin
            sel_any[c] = 1'b1;
            sel_st[c]  = starved[i];
            sel_idx[c] = IDX_W'(i);
            sel_tag[c] = tag[i];
            sel_age[c] = age[i];
          end
        end
      end
      // A killed occupant frees the port for a same-cycle replacement.
      load[c] = !vld_q[c] | iss.fu_ready[c] | kill[c];
      for (int i = 0; i < NUM_RS; i++) begin
        if (load[c] && sel_any[c] && sel_idx[c] == IDX_W'(i))
          picked[i] = 1'b1;
      end
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (xfer[c] && idx_q[c] == IDX_W'(i)
            && state_q[i] == PENDING && !kill_e[i])
          done[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      vld_d[c] = load[c] ? sel_any[c] : vld_q[c];
      idx_d[c] = idx_q[c];
      tag_d[c] = tag_q[c];
      if (load[c] && sel_any[c]) begin
        idx_d[c] = sel_idx[c];
        tag_d[c] = sel_tag[c];
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      if (elig[i] && !picked[i])
        cnt_d[i] = starved[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
      unique case (1'b1)
        kill_e[i]: state_d[i] = IDLE;
        picked[i]: state_d[i] = PENDING;
        done[i]:   state_d[i] = ISSUED;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      for (int c = 0; c < 3; c++) begin
        idx_q[c] <= '0;
        tag_q[c] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < NUM_RS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      for (int c = 0; c < 3; c++) begin
        idx_q[c] <= idx_d[c];
        tag_q[c] <= tag_d[c];
      end
    end
  end

  assign iss.issue_valid = vld_q;

  always_comb begin
    iss.issue_idx     = '0;
    iss.issue_rob_tag = '0;
    for (int c = 0; c < 3; c++) begin
      iss.issue_idx[IDX_W*c +: IDX_W]         = idx_q[c];
      iss.issue_rob_tag[ROB_TAG_W*c +: ROB_TAG_W] = tag_q[c];
    end
    for (int i = 0; i < NUM_RS; i++)
      issued_vec[i] = state_q[i] != IDLE;
  end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios plus random traffic,
// all cycles compared against a key-ranking reference model.
module tb_rs_issue_scheduler;
  localparam int N = 6;
  localparam int LIM = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] entry_ready = '0;
  logic [N-1:0] entry_free = '0;
  logic [N-1:0] squash_vec = '0;
  logic [2*N-1:0] entry_class = '0;
  logic [5*N-1:0] entry_rob_tag = '0;
  logic [4:0]   rob_head = '0;
  logic [N-1:0] issued_vec;

  int checks = 0;
  int errors = 0;
  int mst [N];
  int mcnt [N];
  int midx [3];
  int mtag [3];
  bit mv [3];
  int hit;

  rs_issue_scheduler_if #(.IDX_W(3), .ROB_TAG_W(5)) iss ();

  rs_issue_scheduler #(
    .NUM_RS(N), .ROB_TAG_W(5), .IDX_W(3), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .entry_ready(entry_ready),
    .entry_class(entry_class),
    .entry_rob_tag(entry_rob_tag),
    .rob_head(rob_head),
    .entry_free(entry_free),
    .squash_vec(squash_vec),
    .iss(iss),
    .issued_vec(issued_vec)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mst[i] = 0;
      mcnt[i] = 0;
    end
    for (int c = 0; c < 3; c++) begin
      mv[c] = 0;
      midx[c] = 0;
      mtag[c] = 0;
    end
  endfunction

  // States: 0 idle, 1 pending, 2 issued. Rank = starved, age, index.
  function automatic void model_step();
    bit kill [N];
    bit elig [N];
    bit pick [N];
    bit xf [N];
    bit ld;
    int cl, best, bkey, key, age;
    for (int i = 0; i < N; i++) begin
      cl = int'(entry_class[2*i +: 2]);
      kill[i] = squash_vec[i] || entry_free[i];
      elig[i] = mst[i] == 0 && entry_ready[i] && cl != 3 && !kill[i];
      pick[i] = 0;
      xf[i] = 0;
    end
    for (int c = 0; c < 3; c++) begin
      if (mv[c] && iss.fu_ready[c]) xf[midx[c]] = 1;
      ld = !mv[c] || iss.fu_ready[c] || kill[midx[c]];
      best = -1;
      bkey = 0;
      for (int i = 0; i < N; i++) begin
        if (elig[i] && int'(entry_class[2*i +: 2]) == c) begin
          age = (int'(entry_rob_tag[5*i +: 5])
                 - int'(rob_head) + 32) % 32;
          key = (mcnt[i] >= LIM ? 0 : 1) * 4096 + age * 16 + i;
          if (best < 0 || key < bkey) begin
            best = i;
            bkey = key;
          end
        end
      end
      if (ld) begin
        mv[c] = best >= 0;
        if (best >= 0) begin
          midx[c] = best;
          mtag[c] = int'(entry_rob_tag[5*best +: 5]);
          pick[best] = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (elig[i] && !pick[i])
        mcnt[i] = mcnt[i] < LIM ? mcnt[i] + 1 : LIM;
      else
        mcnt[i] = 0;
      if (kill[i]) mst[i] = 0;
      else if (pick[i]) mst[i] = 1;
      else if (mst[i] == 1 && xf[i]) mst[i] = 2;
    end
  endfunction

  task automatic compare(string where);
    logic [2:0] ev;
    logic [N-1:0] eis;
    for (int c = 0; c < 3; c++) ev[c] = mv[c];
    for (int i = 0; i < N; i++) eis[i] = mst[i] != 0;
    check({where, ":valid"}, 32'(iss.issue_valid), 32'(ev));
    check({where, ":issued_vec"}, 32'(issued_vec), 32'(eis));
    for (int c = 0; c < 3; c++) begin
      if (mv[c]) begin
        check($sformatf("%s:idx%0d", where, c),
              32'(iss.issue_idx[3*c +: 3]), 32'(midx[c]));
        check($sformatf("%s:tag%0d", where, c),
              32'(iss.issue_rob_tag[5*c +: 5]), 32'(mtag[c]));
      end
    end
  endtask

  task automatic cycle(string where);
    model_step();
    @(posedge clk);
    #1;
    compare(where);
  endtask

  task automatic check_zero(string where);
    check({where, ":valid"}, 32'(iss.issue_valid), 0);
    check({where, ":idx"}, 32'(iss.issue_idx), 0);
    check({where, ":tag"}, 32'(iss.issue_rob_tag), 0);
    check({where, ":issued_vec"}, 32'(issued_vec), 0);
  endtask

  task automatic set_entry(int i, bit rdy, int cl, int tg);
    entry_ready[i] = rdy;
    entry_class[2*i +: 2] = 2'(cl);
    entry_rob_tag[5*i +: 5] = 5'(tg);
  endtask

  task automatic flush();
    entry_ready = '0;
    squash_vec = '0;
    entry_free = '1;
    iss.fu_ready = 3'b111;
    cycle("flush");
    entry_free = '0;
    cycle("flush2");
  endtask

  initial begin
    iss.fu_ready = 3'b000;
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset");

    set_entry(1, 1, 0, 3);
    iss.fu_ready = 3'b111;
    rst_n = 1'b1;
    cycle("release");
    check("release:v0", 32'(iss.issue_valid[0]), 1);
    check("release:idx0", 32'(iss.issue_idx[2:0]), 1);

    flush();
    rob_head = 5'd30;
    set_entry(0, 1, 0, 2);
    set_entry(2, 1, 0, 31);
    cycle("age1");
    check("age:first", 32'(iss.issue_idx[2:0]), 2);
    cycle("age2");
    check("age:second", 32'(iss.issue_idx[2:0]), 0);

    flush();
    rob_head = 5'd0;
    set_entry(4, 1, 2, 5);
    iss.fu_ready = 3'b011;
    cycle("bp_sel");
    check("bp:idx", 32'(iss.issue_idx[8:6]), 4);
    set_entry(5, 1, 2, 6);
    repeat (5) begin
      cycle("bp_hold");
      check("bp:hold_idx", 32'(iss.issue_idx[8:6]), 4);
      check("bp:issued4", 32'(issued_vec[4]), 1);
    end
    iss.fu_ready = 3'b111;
    cycle("bp_go");
    check("bp:nobubble", 32'(iss.issue_valid[2]), 1);
    check("bp:next_idx", 32'(iss.issue_idx[8:6]), 5);

    flush();
    set_entry(0, 1, 1, 1);
    set_entry(1, 1, 1, 2);
    set_entry(2, 1, 1, 3);
    set_entry(3, 1, 1, 10);
    hit = 0;
    for (int k = 1; k <= 12; k++) begin
      for (int i = 0; i < 3; i++) entry_free[i] = mst[i] == 2;
      cycle("starve");
      if (hit == 0 && iss.issue_valid[1]
          && iss.issue_idx[5:3] == 3'd3)
        hit = k;
    end
    entry_free = '0;
    check("starve:cycle", 32'(hit), 9);

    flush();
    set_entry(1, 1, 0, 5);
    iss.fu_ready = 3'b000;
    cycle("sq_sel");
    check("sq:sel_idx", 32'(iss.issue_idx[2:0]), 1);
    entry_ready[1] = 1'b0;
    squash_vec[1] = 1'b1;
    cycle("sq");
    squash_vec[1] = 1'b0;
    check("sq:valid0", 32'(iss.issue_valid[0]), 0);
    check("sq:issued1", 32'(issued_vec[1]), 0);
    iss.fu_ready = 3'b111;
    set_entry(2, 1, 0, 6);
    cycle("fr_sel");
    entry_ready[2] = 1'b0;
    cycle("fr_xfer");
    check("fr:issued2", 32'(issued_vec[2]), 1);
    entry_free[2] = 1'b1;
    entry_ready[2] = 1'b1;
    cycle("fr_free");
    check("fr:idle2", 32'(issued_vec[2]), 0);
    entry_free[2] = 1'b0;
    cycle("fr_again");
    check("fr:reissue_v", 32'(iss.issue_valid[0]), 1);
    check("fr:reissue_idx", 32'(iss.issue_idx[2:0]), 2);

    flush();
    set_entry(0, 1, 0, 7);
    set_entry(1, 1, 0, 7);
    set_entry(3, 1, 3, 0);
    cycle("tie");
    check("tie:idx0", 32'(iss.issue_idx[2:0]), 0);
    repeat (4) begin
      cycle("cls3");
      check("cls3:issued3", 32'(issued_vec[3]), 0);
    end

    flush();
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        entry_ready[i] = ($urandom % 4) != 0;
        entry_free[i] = ($urandom % 6) == 0;
        squash_vec[i] = ($urandom % 12) == 0;
      end
      entry_class = 12'($urandom);
      entry_rob_tag = 30'($urandom);
      rob_head = 5'($urandom);
      iss.fu_ready = 3'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
